// File: rtl/rr_arbiter_n_if.sv
// Requester-side bundle for rr_arbiter_n: requests, handshake and registered grant.
// RR_ARBITER_LOCK_EN adds the lock signal that suppresses the hold-time limit.
interface rr_arbiter_n_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic           active;
    logic [N-1:0]   req;
    logic           done;
`ifdef RR_ARBITER_LOCK_EN
    logic           lock;
`endif
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;

`ifdef RR_ARBITER_LOCK_EN
    modport master (output active, req, done, lock, input gnt, gnt_id, gnt_valid);
    modport slave  (input active, req, done, lock, output gnt, gnt_id, gnt_valid);
`else
    modport master (output active, req, done, input gnt, gnt_id, gnt_valid);
    modport slave  (input active, req, done, output gnt, gnt_id, gnt_valid);
`endif
endinterface

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant, done handshake and hold limit.
// Optional feature macro: RR_ARBITER_LOCK_EN (lock input suppresses the hold-time release).
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = 8,
    parameter int HCW      = $clog2(MAX_HOLD + 1)
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter_n_if.slave bus
);
    localparam int             HW       = (HCW < 1) ? 1 : HCW;
    localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);
    localparam logic [N-1:0]   ONE      = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q;
    logic [N-1:0]   gnt_q;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] ptr_q;
    logic [HW-1:0]  hold_q;

    logic           lock_w;
    logic           timeout_w;
    logic           release_w;
    logic [IDW-1:0] start_w;
    logic           win_vld_d;
    logic [IDW-1:0] win_id_d;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
        return (idx == LAST_ID) ? '0 : idx + 1'b1;
    endfunction

`ifdef RR_ARBITER_LOCK_EN
    assign lock_w = bus.lock;
`else
    assign lock_w = 1'b0;
`endif

    assign timeout_w = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && !lock_w;
    assign release_w = bus.done || !bus.req[id_q] || timeout_w || !bus.active;

    // On release the search starts just past the owner, so it is considered last.
    assign start_w = (state_q == GRANT) ? next_idx(id_q) : ptr_q;

    always_comb begin
        win_vld_d = 1'b0;
        win_id_d  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[(int'(start_w) + i) % N]) begin
                win_vld_d = bus.active;
                win_id_d  = IDW'((int'(start_w) + i) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        state_q <= GRANT;
                        gnt_q   <= ONE << win_id_d;
                        id_q    <= win_id_d;
                        hold_q  <= HW'(1);
                    end
                end
                GRANT: begin
                    if (!release_w) begin
                        if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX))
                            hold_q <= hold_q + 1'b1;
                    end else begin
                        ptr_q <= next_idx(id_q);
                        if (win_vld_d) begin
                            gnt_q  <= ONE << win_id_d;
                            id_q   <= win_id_d;
                            hold_q <= HW'(1);
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            id_q    <= '0;
                            hold_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    id_q    <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = (state_q == GRANT);
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n: cycle model feeds a scoreboard, plus hand-derived grant sequences.
module tb_rr_arbiter_n;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);
`ifdef RR_ARBITER_LOCK_EN
    localparam int MH  = 4;
`else
    localparam int MH  = 8;
`endif

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
        logic [N-1:0]   g;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter_n_if #(.N(N)) bus();
    rr_arbiter_n #(.N(N), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_valid;
    int   m_id, m_ptr, m_hold;

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_ptr = 0; m_hold = 0;
        sb.delete();
    endtask

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic predict();
        bit   rel;
        bit   lk;
        int   start;
        exp_t e;
        lk = 0;
`ifdef RR_ARBITER_LOCK_EN
        lk = bus.lock;
`endif
        start = m_ptr;
        if (m_valid) begin
            rel = bus.done || !bus.req[m_id] || !bus.active || (MH != 0 && m_hold == MH && !lk);
            if (rel) begin
                m_ptr = (m_id + 1) % N; start = m_ptr; m_valid = 0; m_id = 0;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
        if (!m_valid && bus.active) begin
            for (int i = 0; i < N; i++) begin
                if (!m_valid && bus.req[(start + i) % N]) begin
                    m_valid = 1; m_id = (start + i) % N; m_hold = 1;
                end
            end
        end
        e.v  = m_valid;
        e.id = IDW'(m_id);
        e.g  = m_valid ? (N'(1) << m_id) : '0;
        sb.push_back(e);
    endtask

    task automatic cycle();
        predict();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.active = 1'b0; bus.req = '0; bus.done = 1'b0;
`ifdef RR_ARBITER_LOCK_EN
        bus.lock = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.active = 1'b1; bus.req = '1; bus.done = 1'b0;
`ifdef RR_ARBITER_LOCK_EN
        bus.lock = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.gnt_valid); end
        checks++; if (bus.gnt_id !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.gnt_id); end
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        exp_t         e;
        logic [N-1:0] want;
        do_reset();
        bus.active = 1'b1; bus.req = 4'b1111;
        for (int j = 0; j < 16; j++) begin
            cycle();
            e = sb.pop_front();
            want = N'(1) << ((j / 2) % N);
            checks++;
            if (bus.gnt !== want || bus.gnt_id !== IDW'((j / 2) % N)) begin
                errors++; $display("FAIL rot_order edge %0d: gnt=%b id=%0d want gnt=%b", j, bus.gnt, bus.gnt_id, want);
            end
            checks++;
            if (bus.gnt !== e.g || bus.gnt_valid !== e.v || (e.v && bus.gnt_id !== e.id)) begin
                errors++; $display("FAIL rot_sb edge %0d: gnt=%b v=%b id=%0d want gnt=%b v=%b id=%0d", j, bus.gnt, bus.gnt_valid, bus.gnt_id, e.g, e.v, e.id);
            end
            bus.done = (j % 2 == 1);
        end
        bus.done = 1'b0;
    endtask

    task automatic test_single_wrap();
        exp_t e;
        do_reset();
        bus.active = 1'b1; bus.req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            bus.done = (k == 1);
            cycle();
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || e.v !== 1'b0) begin
                errors++; $display("FAIL idle_nogrant k=%0d: gnt=%b v=%b want 0000/0", k, bus.gnt, bus.gnt_valid);
            end
        end
        bus.done = 1'b0; bus.req = 4'b0100;
        cycle();
        e = sb.pop_front();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2 || bus.gnt_valid !== 1'b1 || e.g !== 4'b0100) begin
            errors++; $display("FAIL single_grant: gnt=%b id=%0d v=%b want 0100/2/1", bus.gnt, bus.gnt_id, bus.gnt_valid);
        end
        bus.done = 1'b1; bus.req = 4'b0000;
        cycle();
        e = sb.pop_front();
        checks++;
        if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || e.v !== 1'b0) begin
            errors++; $display("FAIL single_release: gnt=%b v=%b want 0000/0", bus.gnt, bus.gnt_valid);
        end
        bus.done = 1'b0; bus.req = 4'b0101;
        cycle();
        e = sb.pop_front();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0 || e.g !== 4'b0001) begin
            errors++; $display("FAIL wrap_grant: gnt=%b id=%0d want 0001/0", bus.gnt, bus.gnt_id);
        end
    endtask

    task automatic test_timeout();
        exp_t         e;
        logic [N-1:0] want;
        do_reset();
        bus.active = 1'b1; bus.req = 4'b0011;
        for (int j = 0; j < 4 * MH; j++) begin
            cycle();
            e = sb.pop_front();
            want = N'(1) << ((j / MH) % 2);
            checks++;
            if (bus.gnt !== want || bus.gnt !== e.g || bus.gnt_valid !== e.v) begin
                errors++; $display("FAIL timeout_alt edge %0d: gnt=%b want %b (model %b)", j, bus.gnt, want, e.g);
            end
        end
        do_reset();
        bus.active = 1'b1; bus.req = 4'b0001;
        for (int j = 0; j <= 2 * MH; j++) begin
            cycle();
            e = sb.pop_front();
            want = (j < 2 * MH) ? 4'b0001 : 4'b0010;
            checks++;
            if (bus.gnt !== want || bus.gnt !== e.g) begin
                errors++; $display("FAIL timeout_sole edge %0d: gnt=%b want %b (model %b)", j, bus.gnt, want, e.g);
            end
            if (j == MH + 1) bus.req = 4'b0011;
        end
    endtask

    task automatic test_active_abort();
        exp_t e;
        do_reset();
        bus.active = 1'b1; bus.req = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1 || e.g !== 4'b0010) begin
                errors++; $display("FAIL abort_owner k=%0d: gnt=%b id=%0d want 0010/1", k, bus.gnt, bus.gnt_id);
            end
        end
        bus.active = 1'b0; bus.req = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || e.v !== 1'b0) begin
                errors++; $display("FAIL abort_inactive k=%0d: gnt=%b v=%b want 0000/0", k, bus.gnt, bus.gnt_valid);
            end
        end
        bus.active = 1'b1;
        cycle();
        e = sb.pop_front();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0 || e.g !== 4'b0001) begin
            errors++; $display("FAIL abort_resume: gnt=%b id=%0d want 0001/0", bus.gnt, bus.gnt_id);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        bus.active = 1'b1; bus.req = 4'b0010;
        cycle();
        e = sb.pop_front();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.gnt !== e.g) begin
            errors++; $display("FAIL areset_pre: gnt=%b want 0010", bus.gnt);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== '0) begin
            errors++; $display("FAIL areset_clear: gnt=%b v=%b id=%0d want 0000/0/0", bus.gnt, bus.gnt_valid, bus.gnt_id);
        end
        model_reset();
        bus.req = 4'b1000;
        #2;
        rst_n = 1'b1;
        cycle();
        e = sb.pop_front();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.gnt_id !== 2'd3 || bus.gnt_valid !== 1'b1 || e.g !== 4'b1000) begin
            errors++; $display("FAIL areset_after: gnt=%b id=%0d v=%b want 1000/3/1", bus.gnt, bus.gnt_id, bus.gnt_valid);
        end
    endtask

`ifdef RR_ARBITER_LOCK_EN
    task automatic test_lock();
        exp_t         e;
        logic [N-1:0] want;
        do_reset();
        bus.active = 1'b1; bus.req = 4'b0011; bus.lock = 1'b1;
        for (int j = 0; j < 2 * MH + 2; j++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (bus.gnt !== 4'b0001 || bus.gnt !== e.g) begin
                errors++; $display("FAIL lock_hold edge %0d: gnt=%b want 0001", j, bus.gnt);
            end
        end
        bus.done = 1'b1;
        cycle();
        e = sb.pop_front();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.gnt !== e.g) begin
            errors++; $display("FAIL lock_done: gnt=%b want 0010", bus.gnt);
        end
        bus.done = 1'b0; bus.lock = 1'b0;
        for (int j = 1; j <= MH; j++) begin
            cycle();
            e = sb.pop_front();
            want = (j < MH) ? 4'b0010 : 4'b0001;
            checks++;
            if (bus.gnt !== want || bus.gnt !== e.g) begin
                errors++; $display("FAIL lock_off edge %0d: gnt=%b want %b", j, bus.gnt, want);
            end
        end
    endtask
`endif

    initial begin
        bus.active = 1'b0; bus.req = '0; bus.done = 1'b0;
`ifdef RR_ARBITER_LOCK_EN
        bus.lock = 1'b0;
`endif
        test_reset();
        test_rotation();
        test_single_wrap();
        test_timeout();
        test_active_abort();
        test_async_reset();
`ifdef RR_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
